regfile_wb_sink: RTL

- Architectural register file at the receiving end of the writeback stage's GP and SR write ports.
- Holds the GP and SR banks and serves registered read ports to decode.
- Forwards a same-cycle writeback into read data (bypass).
- Keeps a per-register in-flight scoreboard that decode uses to stall on read-after-write hazards until writeback retires the write.

---
 rtl/regfile_wb_sink_if.sv | 54 +++++
 rtl/regfile_wb_sink.sv | 139 +++++++++++++
 2 files changed

// File: rtl/regfile_wb_sink_if.sv
// Writeback / decode bundle for regfile_wb_sink.
// The master side (writeback + decode) drives writes, read addresses and
// issue notifications; the slave side (register file) returns read data,
// the hazard flag and the issue-full back-pressure.
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif

interface regfile_wb_sink_if;
    logic [`SIZE_TGT_GP-1:0] iw_gp_write_addr;
    logic [`SIZE_DATA-1:0]   iw_gp_write_data;
    logic                    iw_gp_write_enable;
    logic [`SIZE_TGT_SR-1:0] iw_sr_write_addr;
    logic [`SIZE_DATA-1:0]   iw_sr_write_data;
    logic                    iw_sr_write_enable;
    logic [`SIZE_TGT_GP-1:0] iw_rd_a_addr;
    logic [`SIZE_TGT_GP-1:0] iw_rd_b_addr;
    logic [`SIZE_TGT_SR-1:0] iw_rd_sr_addr;
    logic [`SIZE_DATA-1:0]   ow_rd_a_data;
    logic [`SIZE_DATA-1:0]   ow_rd_b_data;
    logic [`SIZE_DATA-1:0]   ow_rd_sr_data;
    logic                    iw_issue_gp_valid;
    logic [`SIZE_TGT_GP-1:0] iw_issue_gp_tgt;
    logic                    iw_issue_sr_valid;
    logic [`SIZE_TGT_SR-1:0] iw_issue_sr_tgt;
    logic                    ow_hazard;
    logic                    ow_issue_full;

    modport master (
        output iw_gp_write_addr, iw_gp_write_data, iw_gp_write_enable,
        output iw_sr_write_addr, iw_sr_write_data, iw_sr_write_enable,
        output iw_rd_a_addr, iw_rd_b_addr, iw_rd_sr_addr,
        output iw_issue_gp_valid, iw_issue_gp_tgt,
        output iw_issue_sr_valid, iw_issue_sr_tgt,
        input  ow_rd_a_data, ow_rd_b_data, ow_rd_sr_data,
        input  ow_hazard, ow_issue_full
    );

    modport slave (
        input  iw_gp_write_addr, iw_gp_write_data, iw_gp_write_enable,
        input  iw_sr_write_addr, iw_sr_write_data, iw_sr_write_enable,
        input  iw_rd_a_addr, iw_rd_b_addr, iw_rd_sr_addr,
        input  iw_issue_gp_valid, iw_issue_gp_tgt,
        input  iw_issue_sr_valid, iw_issue_sr_tgt,
        output ow_rd_a_data, ow_rd_b_data, ow_rd_sr_data,
        output ow_hazard, ow_issue_full
    );
endinterface

// File: rtl/regfile_wb_sink.sv
// Architectural GP/SR register file sitting at the writeback write ports.
// Registered read ports with same-cycle write bypass, plus a per-register
// saturating count of in-flight writes used by decode for RAW stalls.
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif

module regfile_wb_sink #(
    parameter int N_GP         = 16,
    parameter int N_SR         = 4,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic               iw_clk,
    input  logic               iw_rst,
    regfile_wb_sink_if.slave   wb
);
    localparam int GP_AW = `SIZE_TGT_GP;
    localparam int SR_AW = `SIZE_TGT_SR;
    localparam int DW    = `SIZE_DATA;
    localparam logic [1:0] CNT_MAX = 2'(MAX_INFLIGHT);

    logic [DW-1:0] gp_mem_reg [N_GP];
    logic [DW-1:0] sr_mem_reg [N_SR];

    logic [DW-1:0] rd_a_data_reg;
    logic [DW-1:0] rd_b_data_reg;
    logic [DW-1:0] rd_sr_data_reg;

    logic [N_GP-1:0][1:0] gp_cnt_reg;
    logic [N_GP-1:0][1:0] gp_cnt_next;
    logic [N_SR-1:0][1:0] sr_cnt_reg;
    logic [N_SR-1:0][1:0] sr_cnt_next;

    // A pending count still blocks unless the only outstanding write lands now.
    function automatic logic pending(input logic [1:0] cnt, input logic credit);
        return cnt > {1'b0, credit};
    endfunction

    // Next-count for each GP register: +1 on issue (saturating), -1 on write
    // (floored at 0); an issue and a write on the same register cancel.
    for (genvar gi = 0; gi < N_GP; gi++) begin : g_gp_cnt
        logic       inc;
        logic       dec;
        logic [1:0] cnt_nxt;
        assign inc = wb.iw_issue_gp_valid  && (wb.iw_issue_gp_tgt  == GP_AW'(gi));
        assign dec = wb.iw_gp_write_enable && (wb.iw_gp_write_addr == GP_AW'(gi));
        // Counter update rule for this register.
        always_comb begin
            cnt_nxt = gp_cnt_reg[gi];
            if (inc && !dec) begin
                if (gp_cnt_reg[gi] != CNT_MAX) cnt_nxt = gp_cnt_reg[gi] + 2'd1;
            end else if (dec && !inc) begin
                if (gp_cnt_reg[gi] != 2'd0) cnt_nxt = gp_cnt_reg[gi] - 2'd1;
            end
        end
        assign gp_cnt_next[gi] = cnt_nxt;
    end

    // Same counter rule for the SR bank.
    for (genvar gi = 0; gi < N_SR; gi++) begin : g_sr_cnt
        logic       inc;
        logic       dec;
        logic [1:0] cnt_nxt;
        assign inc = wb.iw_issue_sr_valid  && (wb.iw_issue_sr_tgt  == SR_AW'(gi));
        assign dec = wb.iw_sr_write_enable && (wb.iw_sr_write_addr == SR_AW'(gi));
        // Counter update rule for this register.
        always_comb begin
            cnt_nxt = sr_cnt_reg[gi];
            if (inc && !dec) begin
                if (sr_cnt_reg[gi] != CNT_MAX) cnt_nxt = sr_cnt_reg[gi] + 2'd1;
            end else if (dec && !inc) begin
                if (sr_cnt_reg[gi] != 2'd0) cnt_nxt = sr_cnt_reg[gi] - 2'd1;
            end
        end
        assign sr_cnt_next[gi] = cnt_nxt;
    end

    // Scoreboard counters; reset drops every in-flight write.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            gp_cnt_reg <= '0;
            sr_cnt_reg <= '0;
        end else begin
            gp_cnt_reg <= gp_cnt_next;
            sr_cnt_reg <= sr_cnt_next;
        end
    end

    // Register banks: independent GP and SR write ports.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            for (int i = 0; i < N_GP; i++) gp_mem_reg[i] <= '0;
            for (int i = 0; i < N_SR; i++) sr_mem_reg[i] <= '0;
        end else begin
            if (wb.iw_gp_write_enable) gp_mem_reg[wb.iw_gp_write_addr] <= wb.iw_gp_write_data;
            if (wb.iw_sr_write_enable) sr_mem_reg[wb.iw_sr_write_addr] <= wb.iw_sr_write_data;
        end
    end

    // Registered read ports; a write landing on the read address wins over the array.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            rd_a_data_reg  <= '0;
            rd_b_data_reg  <= '0;
            rd_sr_data_reg <= '0;
        end else begin
            rd_a_data_reg <= (wb.iw_gp_write_enable && wb.iw_gp_write_addr == wb.iw_rd_a_addr)
                           ? wb.iw_gp_write_data : gp_mem_reg[wb.iw_rd_a_addr];
            rd_b_data_reg <= (wb.iw_gp_write_enable && wb.iw_gp_write_addr == wb.iw_rd_b_addr)
                           ? wb.iw_gp_write_data : gp_mem_reg[wb.iw_rd_b_addr];
            rd_sr_data_reg <= (wb.iw_sr_write_enable && wb.iw_sr_write_addr == wb.iw_rd_sr_addr)
                            ? wb.iw_sr_write_data : sr_mem_reg[wb.iw_rd_sr_addr];
        end
    end

    assign wb.ow_rd_a_data  = rd_a_data_reg;
    assign wb.ow_rd_b_data  = rd_b_data_reg;
    assign wb.ow_rd_sr_data = rd_sr_data_reg;

    assign wb.ow_hazard =
          pending(gp_cnt_reg[wb.iw_rd_a_addr],
                  wb.iw_gp_write_enable && wb.iw_gp_write_addr == wb.iw_rd_a_addr)
        | pending(gp_cnt_reg[wb.iw_rd_b_addr],
                  wb.iw_gp_write_enable && wb.iw_gp_write_addr == wb.iw_rd_b_addr)
        | pending(sr_cnt_reg[wb.iw_rd_sr_addr],
                  wb.iw_sr_write_enable && wb.iw_sr_write_addr == wb.iw_rd_sr_addr);

    assign wb.ow_issue_full =
          (wb.iw_issue_gp_valid && gp_cnt_reg[wb.iw_issue_gp_tgt] == CNT_MAX &&
           !(wb.iw_gp_write_enable && wb.iw_gp_write_addr == wb.iw_issue_gp_tgt))
        | (wb.iw_issue_sr_valid && sr_cnt_reg[wb.iw_issue_sr_tgt] == CNT_MAX &&
           !(wb.iw_sr_write_enable && wb.iw_sr_write_addr == wb.iw_issue_sr_tgt));
endmodule
